// File: rtl/umtrx_rx_packet_mux.sv
// umtrx_rx_packet_mux
//   Two-input packet arbiter in the sys clock domain. It merges whole 36-bit
//   VITA packets from two RX chains onto one stream toward the packet router.
//   Arbitration is round-robin at packet boundaries, and words of different
//   packets are never interleaved. The output is registered through a
//   2-entry skid buffer (output register plus one skid register).
//
//   Word format: [31:0] payload, [32] SOF, [33] EOF, [35:34] occupancy.
//   The whole word passes through unmodified.
//
// Ports:
//   sys_clk, sys_rst_n      clock (rising edge), async active-low reset
//   chan_en[1:0]            channel enable mask, sampled only in IDLE
//   in0_* / in1_*           valid/ready input streams
//   out_data/valid/ready    merged output stream
//   grant[1:0]              one-hot active channel, 2'b00 in IDLE
//   proto_err               1-cycle pulse on an SOF framing violation
//   stats_clr, pkt_cnt0/1   per-input EOF counters, present only when
//                           UMTRX_RX_MUX_STATS_EN is defined
//
// Parameters:
//   DEFAULT_EN              reset value of the internal channel-enable mask

module umtrx_rx_packet_mux #(
    parameter logic [1:0] DEFAULT_EN = 2'b11
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [1:0]  chan_en,
    input  logic [35:0] in0_data,
    input  logic        in0_valid,
    output logic        in0_ready,
    input  logic [35:0] in1_data,
    input  logic        in1_valid,
    output logic        in1_ready,
    output logic [35:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  grant,
    output logic        proto_err
`ifdef UMTRX_RX_MUX_STATS_EN
    ,
    input  logic        stats_clr,
    output logic [31:0] pkt_cnt0,
    output logic [31:0] pkt_cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS0 = 2'd1,
        PASS1 = 2'd2
    } state_t;

    state_t      state_q;
    state_t      next_state;
    logic        last_grant_q;   // index of the channel that finished last
    logic        first_q;        // next transfer is the first of the packet
    logic [1:0]  en_q;           // mask captured while IDLE, frozen in PASSn
    logic [35:0] out_data_q;
    logic        out_valid_q;
    logic [35:0] skid_data_q;
    logic        skid_valid_q;
    logic        proto_err_q;

    logic        cand0;
    logic        cand1;
    logic        xfer0;
    logic        xfer1;
    logic        xfer;
    logic [35:0] sel_data;
    logic        sel_sof;
    logic        sel_eof;

    assign cand0 = in0_valid & chan_en[0];
    assign cand1 = in1_valid & chan_en[1];

    // Upstream may only push while the skid register is free, so the output
    // register can always absorb a word or hand it off to the skid slot.
    assign in0_ready = (state_q == PASS0) & en_q[0] & ~skid_valid_q;
    assign in1_ready = (state_q == PASS1) & en_q[1] & ~skid_valid_q;

    assign xfer0 = in0_valid & in0_ready;
    assign xfer1 = in1_valid & in1_ready;
    assign xfer  = xfer0 | xfer1;

    assign sel_data = (state_q == PASS1) ? in1_data : in0_data;
    assign sel_sof  = sel_data[32];
    assign sel_eof  = sel_data[33];

    assign grant     = {state_q == PASS1, state_q == PASS0};
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign proto_err = proto_err_q;

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE: begin
                if (cand0 && cand1) begin
                    // Contention: the channel that did not finish last wins.
                    next_state = last_grant_q ? PASS0 : PASS1;
                end else if (cand0) begin
                    next_state = PASS0;
                end else if (cand1) begin
                    next_state = PASS1;
                end
            end
            PASS0, PASS1: begin
                if (xfer && sel_eof) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            first_q      <= 1'b1;
            en_q         <= DEFAULT_EN;
            proto_err_q  <= 1'b0;
        end else begin
            state_q <= next_state;
            if (state_q == IDLE) begin
                en_q <= chan_en;
            end
            if (xfer && sel_eof) begin
                last_grant_q <= (state_q == PASS1);
            end
            if (state_q == IDLE) begin
                first_q <= 1'b1;
            end else if (xfer) begin
                first_q <= 1'b0;
            end
            // Framing check only flags; the word is still forwarded.
            proto_err_q <= xfer & (first_q ? ~sel_sof : sel_sof);
        end
    end

    // ------------------------------------------------------------------
    // Skid buffer
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // Output register is free this cycle: drain the skid slot first
            // (no new word can arrive then, ready was low) to keep order.
            if (skid_valid_q) begin
                out_data_q   <= skid_data_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (xfer) begin
                out_data_q  <= sel_data;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (xfer) begin
            skid_data_q  <= sel_data;
            skid_valid_q <= 1'b1;
        end
    end

`ifdef UMTRX_RX_MUX_STATS_EN
    // ------------------------------------------------------------------
    // Packet counters (wrap naturally; clear has priority over increment)
    // ------------------------------------------------------------------
    logic [31:0] cnt0_q;
    logic [31:0] cnt1_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (stats_clr) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (xfer0 && in0_data[33]) begin
                cnt0_q <= cnt0_q + 32'd1;
            end
            if (xfer1 && in1_data[33]) begin
                cnt1_q <= cnt1_q + 32'd1;
            end
        end
    end

    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_umtrx_rx_packet_mux.sv
// Directed testbench for umtrx_rx_packet_mux. Build with
// UMTRX_RX_MUX_STATS_EN defined to also exercise the packet counters.

module tb_umtrx_rx_packet_mux;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [1:0]  chan_en;
    logic [35:0] in0_data;
    logic        in0_valid;
    logic        in0_ready;
    logic [35:0] in1_data;
    logic        in1_valid;
    logic        in1_ready;
    logic [35:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  grant;
    logic        proto_err;
`ifdef UMTRX_RX_MUX_STATS_EN
    logic        stats_clr;
    logic [31:0] pkt_cnt0;
    logic [31:0] pkt_cnt1;
`endif

    umtrx_rx_packet_mux #(.DEFAULT_EN(2'b11)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .chan_en   (chan_en),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant     (grant),
        .proto_err (proto_err)
`ifdef UMTRX_RX_MUX_STATS_EN
        ,
        .stats_clr (stats_clr),
        .pkt_cnt0  (pkt_cnt0),
        .pkt_cnt1  (pkt_cnt1)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    int          err_cnt = 0;
    logic [35:0] q0[$];
    logic [35:0] q1[$];
    logic [35:0] oq[$];
    int          os[$];
    logic        acc0;
    logic        acc1;

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic logic [35:0] mkw(input logic [31:0] p, input logic sof,
                                        input logic eof, input logic [1:0] occ);
        return {occ, eof, sof, p};
    endfunction

    // Source for input 0: shows the head of q0, pops it once accepted.
    initial begin
        in0_valid = 1'b0;
        in0_data  = '0;
        forever begin
            @(negedge sys_clk);
            acc0 = in0_valid && in0_ready;
            @(posedge sys_clk);
            #1;
            if (acc0 && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                in0_data  = q0[0];
                in0_valid = 1'b1;
            end else begin
                in0_valid = 1'b0;
            end
        end
    end

    initial begin
        in1_valid = 1'b0;
        in1_data  = '0;
        forever begin
            @(negedge sys_clk);
            acc1 = in1_valid && in1_ready;
            @(posedge sys_clk);
            #1;
            if (acc1 && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                in1_data  = q1[0];
                in1_valid = 1'b1;
            end else begin
                in1_valid = 1'b0;
            end
        end
    end

    // Sink: records every accepted output word with its cycle stamp.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n === 1'b1 && out_valid && out_ready) begin
                oq.push_back(out_data);
                os.push_back(cyc);
            end
            if (proto_err === 1'b1) err_cnt++;
        end
    end

    task automatic send(input int ch, input logic [31:0] base, input int len,
                        input logic [1:0] occ);
        for (int i = 0; i < len; i++) begin
            if (ch == 0) q0.push_back(mkw(base + i, i == 0, i == len - 1, occ));
            else         q1.push_back(mkw(base + i, i == 0, i == len - 1, occ));
        end
    endtask

    task automatic wait_out(input int n, input int budget);
        for (int k = 0; k < budget && oq.size() < n; k++) @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        oq.delete();
        os.delete();
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        chan_en   = 2'b11;
        out_ready = 1'b1;
`ifdef UMTRX_RX_MUX_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (3) @(posedge sys_clk);
        #1;
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        n_assert++; if (out_data !== 36'h0) begin n_fail++; $display("FAIL reset_out_data: got %h required 0", out_data); end
        n_assert++; if (in0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in0_ready: got %b required 0", in0_ready); end
        n_assert++; if (in1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in1_ready: got %b required 0", in1_ready); end
        n_assert++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b required 00", grant); end
        n_assert++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %b required 0", proto_err); end
`ifdef UMTRX_RX_MUX_STATS_EN
        n_assert++; if (pkt_cnt0 !== 32'h0) begin n_fail++; $display("FAIL reset_pkt_cnt0: got %h required 0", pkt_cnt0); end
`endif
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        n_assert++; if (grant !== 2'b00) begin n_fail++; $display("FAIL idle_grant: got %b required 00", grant); end
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid: got %b required 0", out_valid); end
    endtask

    task automatic test_single_packet();
        logic [35:0] exp[$];
        oq.delete(); os.delete();
        for (int i = 0; i < 4; i++) exp.push_back(mkw(32'h100 + i, i == 0, i == 3, 2'b10));
        send(0, 32'h100, 4, 2'b10);
        for (int k = 0; k < 40 && oq.size() < 4; k++) begin
            @(negedge sys_clk);
            if (in0_valid && in0_ready) begin
                n_assert++;
                if (grant !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b required 01", grant); end
            end
        end
        n_assert++; if (oq.size() != 4) begin n_fail++; $display("FAIL single_count: got %0d words required 4", oq.size()); end
        for (int i = 0; i < 4 && i < oq.size(); i++) begin
            n_assert++; if (oq[i] !== exp[i]) begin n_fail++; $display("FAIL single_data[%0d]: got %h required %h", i, oq[i], exp[i]); end
            n_assert++; if (os[i] != os[0] + i) begin n_fail++; $display("FAIL single_cycle[%0d]: got %0d required %0d", i, os[i], os[0] + i); end
        end
        @(negedge sys_clk);
        n_assert++; if (grant !== 2'b00) begin n_fail++; $display("FAIL single_back_idle: got %b required 00", grant); end
    endtask

    task automatic test_round_robin();
        logic [35:0] exp[$];
        do_reset();
        for (int i = 0; i < 3; i++) exp.push_back(mkw(32'h200 + i, i == 0, i == 2, 2'b01));
        for (int i = 0; i < 3; i++) exp.push_back(mkw(32'h300 + i, i == 0, i == 2, 2'b10));
        for (int i = 0; i < 3; i++) exp.push_back(mkw(32'h210 + i, i == 0, i == 2, 2'b01));
        for (int i = 0; i < 3; i++) exp.push_back(mkw(32'h310 + i, i == 0, i == 2, 2'b10));
        send(0, 32'h200, 3, 2'b01);
        send(0, 32'h210, 3, 2'b01);
        send(1, 32'h300, 3, 2'b10);
        send(1, 32'h310, 3, 2'b10);
        wait_out(12, 80);
        n_assert++; if (oq.size() != 12) begin n_fail++; $display("FAIL rr_count: got %0d words required 12", oq.size()); end
        for (int i = 0; i < 12 && i < oq.size(); i++) begin
            n_assert++; if (oq[i] !== exp[i]) begin n_fail++; $display("FAIL rr_data[%0d]: got %h required %h", i, oq[i], exp[i]); end
        end
        for (int i = 1; i < 12 && i < oq.size(); i++) begin
            int gap;
            gap = (i % 3 == 0) ? 2 : 1;
            n_assert++; if (os[i] - os[i-1] != gap) begin n_fail++; $display("FAIL rr_gap[%0d]: got %0d required %0d", i, os[i] - os[i-1], gap); end
        end
    endtask

    task automatic test_backpressure();
        logic [35:0] exp[$];
        logic        pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic        skid_m = 1'b0;
        logic        skid_n;
        logic        saw_skid = 1'b0;
        oq.delete(); os.delete();
        for (int i = 0; i < 8; i++) exp.push_back(mkw(32'h400 + i, i == 0, i == 7, 2'b11));
        send(1, 32'h400, 8, 2'b11);
        for (int k = 0; k < 120 && oq.size() < 8; k++) begin
            @(posedge sys_clk);
            skid_m = skid_n;
            #2;
            out_ready = pat[k % 6];
            @(negedge sys_clk);
            if (skid_m) begin
                saw_skid = 1'b1;
                n_assert++;
                if (in1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_skid_full: got %b required 0", in1_ready); end
            end
            if (skid_m) skid_n = out_valid && !out_ready;
            else        skid_n = out_valid && !out_ready && in1_valid && in1_ready;
        end
        out_ready = 1'b1;
        repeat (5) @(negedge sys_clk);
        n_assert++; if (!saw_skid) begin n_fail++; $display("FAIL bp_skid_used: got 0 required 1"); end
        n_assert++; if (oq.size() != 8) begin n_fail++; $display("FAIL bp_count: got %0d words required 8", oq.size()); end
        for (int i = 0; i < 8 && i < oq.size(); i++) begin
            n_assert++; if (oq[i] !== exp[i]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h required %h", i, oq[i], exp[i]); end
        end
    endtask

    task automatic test_chan_en();
        logic [35:0] exp[$];
        int n1 = 0;
        oq.delete(); os.delete();
        @(negedge sys_clk);
        chan_en = 2'b10;
        for (int i = 0; i < 6; i++) exp.push_back(mkw(32'h600 + i, i == 0, i == 5, 2'b00));
        for (int i = 0; i < 3; i++) exp.push_back(mkw(32'h500 + i, i == 0, i == 2, 2'b01));
        for (int i = 0; i < 3; i++) exp.push_back(mkw(32'h610 + i, i == 0, i == 2, 2'b00));
        send(0, 32'h500, 3, 2'b01);
        send(1, 32'h600, 6, 2'b00);
        send(1, 32'h610, 3, 2'b00);
        for (int k = 0; k < 80 && oq.size() < 12; k++) begin
            @(negedge sys_clk);
            if (grant == 2'b10) begin
                n_assert++;
                if (in0_ready !== 1'b0) begin n_fail++; $display("FAIL en_in0_ready: got %b required 0", in0_ready); end
            end
            if (in1_valid && in1_ready) begin
                n1++;
                if (n1 == 2) chan_en = 2'b11;
            end
        end
        n_assert++; if (oq.size() != 12) begin n_fail++; $display("FAIL en_count: got %0d words required 12", oq.size()); end
        for (int i = 0; i < 12 && i < oq.size(); i++) begin
            n_assert++; if (oq[i] !== exp[i]) begin n_fail++; $display("FAIL en_data[%0d]: got %h required %h", i, oq[i], exp[i]); end
        end
    endtask

    task automatic test_proto_err();
        logic [35:0] exp[$];
        oq.delete(); os.delete();
        err_cnt = 0;
        for (int i = 0; i < 3; i++) exp.push_back(mkw(32'h700 + i, 1'b0, i == 2, 2'b01));
        for (int i = 0; i < 4; i++) exp.push_back(mkw(32'h710 + i, i == 0 || i == 2, i == 3, 2'b11));
        for (int i = 0; i < 7; i++) q0.push_back(exp[i]);
        wait_out(7, 60);
        repeat (3) @(negedge sys_clk);
        n_assert++; if (err_cnt != 2) begin n_fail++; $display("FAIL perr_pulses: got %0d required 2", err_cnt); end
        n_assert++; if (oq.size() != 7) begin n_fail++; $display("FAIL perr_count: got %0d words required 7", oq.size()); end
        for (int i = 0; i < 7 && i < oq.size(); i++) begin
            n_assert++; if (oq[i] !== exp[i]) begin n_fail++; $display("FAIL perr_data[%0d]: got %h required %h", i, oq[i], exp[i]); end
        end
    endtask

`ifdef UMTRX_RX_MUX_STATS_EN
    task automatic test_stats();
        int k;
        oq.delete(); os.delete();
        @(negedge sys_clk); stats_clr = 1'b1;
        @(negedge sys_clk); stats_clr = 1'b0;
        for (int i = 0; i < 3; i++) send(0, 32'h800 + 16 * i, 2, 2'b00);
        for (int i = 0; i < 2; i++) send(1, 32'h900 + 16 * i, 2, 2'b00);
        wait_out(10, 100);
        repeat (2) @(negedge sys_clk);
        n_assert++; if (pkt_cnt0 !== 32'd3) begin n_fail++; $display("FAIL stats_cnt0: got %0d required 3", pkt_cnt0); end
        n_assert++; if (pkt_cnt1 !== 32'd2) begin n_fail++; $display("FAIL stats_cnt1: got %0d required 2", pkt_cnt1); end
        // Clear asserted for the same edge that accepts an EOF word on in0.
        send(0, 32'hA00, 1, 2'b00);
        k = 0;
        while (k < 30 && !(in0_valid && in0_ready)) begin @(negedge sys_clk); k++; end
        n_assert++; if (k >= 30) begin n_fail++; $display("FAIL stats_clr_timeout: got no transfer required one"); end
        stats_clr = 1'b1;
        @(negedge sys_clk);
        stats_clr = 1'b0;
        n_assert++; if (pkt_cnt0 !== 32'd0) begin n_fail++; $display("FAIL stats_clr_wins: got %0d required 0", pkt_cnt0); end
        n_assert++; if (pkt_cnt1 !== 32'd0) begin n_fail++; $display("FAIL stats_clr_cnt1: got %0d required 0", pkt_cnt1); end
        repeat (3) @(negedge sys_clk);
        force dut.cnt0_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt0_q;
        @(negedge sys_clk);
        n_assert++; if (pkt_cnt0 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL stats_preload: got %h required ffffffff", pkt_cnt0); end
        oq.delete();
        send(0, 32'hB00, 2, 2'b00);
        wait_out(2, 40);
        repeat (2) @(negedge sys_clk);
        n_assert++; if (pkt_cnt0 !== 32'd0) begin n_fail++; $display("FAIL stats_wrap: got %h required 0", pkt_cnt0); end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_chan_en();
        test_proto_err();
`ifdef UMTRX_RX_MUX_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
